// File: rtl/index_decoder_pkg.sv
// Shared definitions for index_decoder and the downstream priority encoder:
// index/bitmap widths, command encodings, FSM state type and a chunk popcount.
package index_decoder_pkg;

  localparam int IDX_W  = 8;
  localparam int N      = 2 ** IDX_W;
  localparam int CHUNK  = 32;
  localparam int NCHUNK = N / CHUNK;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PC_W   = $clog2(CHUNK) + 1;

  localparam logic [1:0] OP_SET       = 2'b00;
  localparam logic [1:0] OP_CLEAR     = 2'b01;
  localparam logic [1:0] OP_TOGGLE    = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Small popcount for a single sweep chunk; avoids a full-width adder tree.
  function automatic logic [PC_W-1:0] popcount_chunk(input logic [CHUNK-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/index_decoder_onehot_decode.sv
// Combinational index-to-one-hot decoder, shared by the bitmap write mask
// and the registered onehot output of index_decoder.
module onehot_decode
  import index_decoder_pkg::*;
#(
  parameter int IW = IDX_W,
  parameter int NW = N
) (
  input  logic [IW-1:0] i_idx,
  output logic [NW-1:0] o_onehot
);

  assign o_onehot = {{(NW-1){1'b0}}, 1'b1} << i_idx;

endmodule

// File: rtl/index_decoder.sv
// Index decoder: per-command set/clear/toggle of a 256-bit bitmap plus a
// registered one-hot decode; CLEAR_ALL sweeps the bitmap one chunk per cycle.
// Optional population counter enabled by defining INDEX_DECODER_COUNT_EN.
module index_decoder
  import index_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  // Handshake: a command transfers on a rising edge where in_valid && in_ready;
  // upstream holds in_idx/in_op stable while in_valid is high and in_ready low.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [1:0]       in_op,
  output logic [N-1:0]     onehot,
  output logic             onehot_valid,
  output logic [N-1:0]     out_vec,
  output logic             out_any,
`ifdef INDEX_DECODER_COUNT_EN
  output logic [IDX_W:0]   count,
`endif
  output state_t           dbg_state
);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     r_vec;
  logic [N-1:0]     r_onehot;
  logic             r_onehot_valid;
  logic             r_any;

  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_vec_next;
  logic             w_accept;
  logic             w_bit_op;

  onehot_decode #(.IW(IDX_W), .NW(N)) u_decode (
    .i_idx    (in_idx),
    .o_onehot (w_mask)
  );

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_bit_op = w_accept && (in_op != OP_CLEAR_ALL);

  always_comb begin
    w_vec_next = r_vec;
    if (w_bit_op) begin
      case (in_op)
        OP_SET:    w_vec_next = r_vec | w_mask;
        OP_CLEAR:  w_vec_next = r_vec & ~w_mask;
        OP_TOGGLE: w_vec_next = r_vec ^ w_mask;
        default:   w_vec_next = r_vec;
      endcase
    end else if (r_state == ST_SWEEP) begin
      w_vec_next[r_ptr*CHUNK +: CHUNK] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_vec          <= '0;
      r_onehot       <= '0;
      r_onehot_valid <= 1'b0;
      r_any          <= 1'b0;
    end else begin
      r_vec          <= w_vec_next;
      r_any          <= |w_vec_next;
      r_onehot_valid <= w_bit_op;
      if (w_bit_op) begin
        r_onehot <= w_mask;
      end else if (w_accept) begin
        r_onehot <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept && in_op == OP_CLEAR_ALL) begin
            r_state <= ST_SWEEP;
            r_ptr   <= '0;
          end
        end
        ST_SWEEP: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == PTR_W'(NCHUNK - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef INDEX_DECODER_COUNT_EN
  logic [IDX_W:0]   r_count;
  logic [IDX_W:0]   w_count_next;
  logic [CHUNK-1:0] w_chunk;
  logic             w_prior;

  assign w_chunk = r_vec[r_ptr*CHUNK +: CHUNK];
  assign w_prior = |(r_vec & w_mask);

  // TOGGLE resolves to +1 or -1 from the bit's value before this edge.
  always_comb begin
    w_count_next = r_count;
    if (w_bit_op) begin
      if ((in_op == OP_SET || in_op == OP_TOGGLE) && !w_prior)
        w_count_next = r_count + 1'b1;
      else if ((in_op == OP_CLEAR || in_op == OP_TOGGLE) && w_prior)
        w_count_next = r_count - 1'b1;
    end else if (r_state == ST_SWEEP) begin
      w_count_next = r_count - (IDX_W+1)'(popcount_chunk(w_chunk));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_count_next;
  end

  assign count = r_count;
`endif

  assign in_ready     = (r_state == ST_IDLE);
  assign onehot       = r_onehot;
  assign onehot_valid = r_onehot_valid;
  assign out_vec      = r_vec;
  assign out_any      = r_any;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_index_decoder.sv
// Directed self-checking bench for index_decoder: reset, repeated set, walking
// index, mixed ops, chunked CLEAR_ALL with a stalled command, reset mid-sweep.
module tb_index_decoder;
  import index_decoder_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [1:0]       in_op;
  logic [N-1:0]     onehot;
  logic             onehot_valid;
  logic [N-1:0]     out_vec;
  logic             out_any;
  logic [IDX_W:0]   count_obs;
  state_t           dbg_state;

  int n_checks;
  int n_fail;

  index_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_idx       (in_idx),
    .in_op        (in_op),
    .onehot       (onehot),
    .onehot_valid (onehot_valid),
    .out_vec      (out_vec),
    .out_any      (out_any),
`ifdef INDEX_DECODER_COUNT_EN
    .count        (count_obs),
`endif
    .dbg_state    (dbg_state)
  );

`ifndef INDEX_DECODER_COUNT_EN
  assign count_obs = '0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef INDEX_DECODER_COUNT_EN
    check(tag, N'(count_obs), N'(exp));
`else
    if (exp < 0) $display("note: %s negative", tag);
`endif
  endtask

  // driver: one command presented for exactly one edge (back-to-back if called in a row)
  task automatic cmd(input logic [1:0] op, input int idx);
    in_valid = 1'b1;
    in_op    = op;
    in_idx   = IDX_W'(idx);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Reference for the downstream priority encoder: highest set bit.
  function automatic int highest(input logic [N-1:0] v);
    int h;
    h = -1;
    for (int i = 0; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  logic [N-1:0] exp_vec;
  int           low_cycles;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_idx   = '0;
    in_op    = OP_SET;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    check("rst_vec", out_vec, '0);
    check("rst_onehot", onehot, '0);
    check("rst_ohv", N'(onehot_valid), '0);
    check("rst_any", N'(out_any), '0);
    check("rst_ready", N'(in_ready), N'(1));
    check("rst_state", N'(dbg_state), N'(ST_IDLE));
    check_count("rst_count", 0);

    // SET 255, then SET 255 again
    cmd(OP_SET, 255);
    check("set255_vec", out_vec, bit_at(255));
    check("set255_onehot", onehot, bit_at(255));
    check("set255_ohv", N'(onehot_valid), N'(1));
    check("set255_any", N'(out_any), N'(1));
    check_count("set255_count", 1);
    tick();
    check("set255_ohv_drop", N'(onehot_valid), '0);
    cmd(OP_SET, 255);
    check("reset255_vec", out_vec, bit_at(255));
    check("reset255_ohv", N'(onehot_valid), N'(1));
    check_count("reset255_count", 1);

    // walking index, back-to-back CLEAR i / SET i-1
    for (int i = 255; i >= 1; i--) begin
      cmd(OP_CLEAR, i);
      cmd(OP_SET, i - 1);
      check("walk_vec", out_vec, bit_at(i - 1));
      check("walk_prio", N'(highest(out_vec)), N'(i - 1));
      check_count("walk_count", 1);
    end
    check("walk_onehot", onehot, bit_at(0));

    // mixed ops; bit 0 is still set from the walk
    cmd(OP_SET, 0);
    cmd(OP_SET, 31);
    cmd(OP_SET, 32);
    cmd(OP_SET, 128);
    cmd(OP_SET, 255);
    cmd(OP_TOGGLE, 32);
    check("tog32_onehot", onehot, bit_at(32));
    cmd(OP_TOGGLE, 64);
    exp_vec = bit_at(0) | bit_at(31) | bit_at(64) | bit_at(128) | bit_at(255);
    check("mix_vec", out_vec, exp_vec);
    check("mix_any", N'(out_any), N'(1));
    check_count("mix_count", 5);
    // back-to-back on one index: toggle then clear must see the toggled bit
    cmd(OP_TOGGLE, 5);
    cmd(OP_CLEAR, 5);
    check("b2b_vec", out_vec, exp_vec);
    check_count("b2b_count", 5);

    // fill all bits, then CLEAR_ALL with SET 7 stalled behind the sweep
    for (int i = 0; i < N; i++) cmd(OP_SET, i);
    check("full_vec", out_vec, '1);
    check_count("full_count", 256);
    cmd(OP_CLEAR_ALL, 0);
    check("ca_onehot", onehot, '0);
    check("ca_ohv", N'(onehot_valid), '0);
    in_valid = 1'b1;
    in_op    = OP_SET;
    in_idx   = IDX_W'(7);
    low_cycles = 0;
    while (!in_ready && low_cycles < 20) begin
      check_count("sweep_count", 256 - 32 * low_cycles);
      check("sweep_vec", out_vec, ~((bit_at(32 * low_cycles)) - 1'b1));
      low_cycles++;
      tick();
    end
    check("sweep_len", N'(low_cycles), N'(8));
    check("sweep_done_vec", out_vec, '0);
    check("sweep_done_any", N'(out_any), '0);
    check_count("sweep_done_count", 0);
    check("sweep_stall_ohv", N'(onehot_valid), '0);
    tick();
    in_valid = 1'b0;
    check("stalled_set7_vec", out_vec, bit_at(7));
    check("stalled_set7_ohv", N'(onehot_valid), N'(1));
    check_count("stalled_set7_count", 1);

    // reset asserted at sweep cycle 3
    cmd(OP_SET, 200);
    cmd(OP_CLEAR_ALL, 0);
    tick();
    tick();
    check("mid_state", N'(dbg_state), N'(ST_SWEEP));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_vec", out_vec, '0);
    check("abort_onehot", onehot, '0);
    check("abort_ohv", N'(onehot_valid), '0);
    check("abort_any", N'(out_any), '0);
    check("abort_ready", N'(in_ready), N'(1));
    check("abort_state", N'(dbg_state), N'(ST_IDLE));
    check_count("abort_count", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
